// File: rtl/edge_pkg.sv
// edge_pkg: shared state encoding and default sizing for the edge-domain blocks.
package edge_pkg;
    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 65535;
endpackage

// File: rtl/edge_period_meter_if.sv
// edge_period_meter_if: valid/ready result channel carrying measured periods.
interface edge_period_meter_if import edge_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
    logic [CNT_W-1:0] period_data;
    logic             period_valid;
    logic             period_ready;
    modport master(output period_data, output period_valid, input period_ready);
    modport slave(input period_data, input period_valid, output period_ready);
endinterface

// File: rtl/period_out_reg.sv
// period_out_reg: one-entry valid/ready holding register; a load into a stalled
// entry is dropped and latches the sticky overrun flag.
module period_out_reg #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);
    logic drop;
    assign drop = load && valid && !ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && !drop) data <= din;
            valid   <= load || (valid && !ready);
            overrun <= overrun || drop;
        end
    end
endmodule

// File: rtl/edge_period_meter.sv
// edge_period_meter: counts clk cycles between edge_in pulses, with timeout and overrun.
// Define EDGE_PERIOD_MINMAX_EN to add running min_period/max_period outputs.
module edge_period_meter import edge_pkg::*; #(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             edge_in,
    input  logic             clear,
    edge_period_meter_if.master period,
    output logic             timeout,
`ifdef EDGE_PERIOD_MINMAX_EN
    output logic             overrun,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
`else
    output logic             overrun
`endif
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tmo_hit, done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            timeout <= tmo_hit;
        end
    end
    // An edge coinciding with cnt==TIMEOUT completes the period instead of timing out.
    always_comb begin
        done    = !clear && state == MEASURE && edge_in;
        tmo_hit = !clear && state == MEASURE && !edge_in && cnt == TMO;
        state_d = (clear || tmo_hit) ? IDLE : edge_in ? MEASURE : state;
        cnt_d   = (clear || tmo_hit) ? '0 : edge_in ? CNT_W'(1) :
                  (state == MEASURE) ? cnt + 1'b1 : '0;
    end
    period_out_reg #(.W(CNT_W)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .load    (done),
        .din     (cnt),
        .ready   (period.period_ready),
        .data    (period.period_data),
        .valid   (period.period_valid),
        .overrun (overrun)
    );
`ifdef EDGE_PERIOD_MINMAX_EN
    // Tracks every completed period, including those dropped by overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            min_period <= '1;
            max_period <= '0;
        end else if (done) begin
            if (cnt < min_period) min_period <= cnt;
            if (cnt > max_period) max_period <= cnt;
        end
    end
`endif
endmodule

// File: tb/tb_edge_period_meter.sv
// tb_edge_period_meter: scoreboard bench; expected periods are queued as edges are
// driven and popped on each valid/ready transfer.
module tb_edge_period_meter;
    import edge_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, edge_in = 1'b0, clear = 1'b0, timeout, overrun;
    int errors = 0, checks = 0;
    logic [15:0] sb[$];
`ifdef EDGE_PERIOD_MINMAX_EN
    logic [15:0] min_period, max_period;
`endif
    edge_period_meter_if #(.CNT_W(16)) pif();
    edge_period_meter #(.CNT_W(16), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .edge_in    (edge_in),
        .clear      (clear),
        .period     (pif),
        .timeout    (timeout),
`ifdef EDGE_PERIOD_MINMAX_EN
        .overrun    (overrun),
        .min_period (min_period),
        .max_period (max_period)
`else
        .overrun    (overrun)
`endif
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        edge_in = 1'b1;
        tick();
        edge_in = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n - 1) tick();
        pulse();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && pif.period_valid && pif.period_ready) begin
            if (sb.size() == 0) check("sb_empty", sb.size(), 1);
            else check("sb_data", pif.period_data, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pif.period_ready = 1'b0;
        repeat (3) tick();
        check("rst_data", pif.period_data, 0);
        check("rst_valid", pif.period_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_overrun", overrun, 0);
`ifdef EDGE_PERIOD_MINMAX_EN
        check("rst_min", min_period, 16'hffff);
        check("rst_max", max_period, 0);
`endif
        rst_n = 1'b1;
        pif.period_ready = 1'b1;
        // edges at cycles 10 and 17
        repeat (9) tick();
        pulse();
        check("first_edge_valid", pif.period_valid, 0);
        sb.push_back(16'd7);
        gap(7);
        check("p7_valid", pif.period_valid, 1);
        check("p7_data", pif.period_data, 7);
        check("p7_timeout", timeout, 0);
        tick();
        check("p7_valid_drop", pif.period_valid, 0);
        // four back-to-back edges
        do_clear();
        repeat (3) sb.push_back(16'd1);
        edge_in = 1'b1;
        tick();
        check("b2b_first", pif.period_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_valid", pif.period_valid, 1);
            check("b2b_data", pif.period_data, 1);
        end
        edge_in = 1'b0;
        tick();
        check("b2b_end", pif.period_valid, 0);
        // timeout after silence, then a fresh measurement
        do_clear();
        pulse();
        repeat (19) tick();
        check("tmo_early", timeout, 0);
        tick();
        check("tmo_pulse", timeout, 1);
        tick();
        check("tmo_once", timeout, 0);
        pulse();
        check("fresh_no_result", pif.period_valid, 0);
        sb.push_back(16'd6);
        gap(6);
        check("fresh_data", pif.period_data, 6);
        // edge on the timeout cycle wins
        sb.push_back(16'd20);
        gap(20);
        check("edge_at_tmo_data", pif.period_data, 20);
        check("edge_at_tmo_valid", pif.period_valid, 1);
        check("edge_at_tmo_notmo", timeout, 0);
        tick();
        check("edge_at_tmo_notmo2", timeout, 0);
        // overrun while stalled
        do_clear();
        pif.period_ready = 1'b0;
        pulse();
        sb.push_back(16'd5);
        gap(5);
        gap(8);
        check("ovr_data_held", pif.period_data, 5);
        check("ovr_valid", pif.period_valid, 1);
        check("ovr_flag", overrun, 1);
        pif.period_ready = 1'b1;
        tick();
        check("ovr_xfer_valid", pif.period_valid, 0);
        check("ovr_sticky", overrun, 1);
        do_clear();
        check("ovr_cleared", overrun, 0);
        // new result on the same cycle as a transfer
        pif.period_ready = 1'b0;
        pulse();
        sb.push_back(16'd4);
        gap(4);
        repeat (5) tick();
        check("xfer_held", pif.period_valid, 1);
        pif.period_ready = 1'b1;
        sb.push_back(16'd6);
        pulse();
        check("xfer_load_valid", pif.period_valid, 1);
        check("xfer_load_data", pif.period_data, 6);
        check("xfer_no_ovr", overrun, 0);
        tick();
        check("xfer_done", pif.period_valid, 0);
        // async reset mid-measurement with a held result
        do_clear();
        pif.period_ready = 1'b0;
        pulse();
        gap(5);
        check("pre_rst_valid", pif.period_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_data", pif.period_data, 0);
        check("arst_valid", pif.period_valid, 0);
        check("arst_timeout", timeout, 0);
        check("arst_overrun", overrun, 0);
        tick();
        rst_n = 1'b1;
        pif.period_ready = 1'b1;
        tick();
        pulse();
        check("post_rst_no_result", pif.period_valid, 0);
        sb.push_back(16'd9);
        gap(9);
        sb.push_back(16'd3);
        gap(3);
        sb.push_back(16'd12);
        gap(12);
        tick();
`ifdef EDGE_PERIOD_MINMAX_EN
        check("min_period", min_period, 3);
        check("max_period", max_period, 12);
`endif
        repeat (2) tick();
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/edge_period_meter.md
Name: edge_period_meter

Overview:
- Downstream consumer of the rising-edge detector's one-cycle `rising_edge` pulse, which arrives here on `edge_in`.
- Measures the number of `clk` cycles between consecutive edges.
- Each completed period is presented on a one-entry valid/ready output register; missing edges are flagged by a timeout, dropped results by a sticky overrun flag.
- Sits between the edge-detect stage and the frequency/status logic.

Parameters:
- CNT_W, 16, width of period counter and result.
- TIMEOUT, 65535, cycles without an edge before the measurement is abandoned. Must satisfy 1 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; asynchronous, active-low
- edge_in  input  1  single-cycle edge pulse, already in the clk domain
- clear  input  1  synchronous soft clear
- period_data  output  CNT_W  measured period in cycles
- period_valid  output  1  period_data holds an unconsumed result
- period_ready  input  1  consumer accepts the result
- timeout  output  1  one-cycle pulse when TIMEOUT is reached
- overrun  output  1  sticky; a result was dropped

Behaviour:
- Reset values:
  - state=IDLE, cnt=0.
  - period_data=0, period_valid=0, timeout=0, overrun=0.
  - All registers clear immediately when rst_n falls, mid-measurement included.
- States: IDLE (waiting for first edge), MEASURE (counting).
- IDLE:
  - cnt held at 0.
  - edge_in=1 -> MEASURE, cnt<=1.
  - Output registers are not touched.
- MEASURE, edge_in=0, cnt<TIMEOUT: cnt<=cnt+1.
- MEASURE, edge_in=1: result=cnt, cnt<=1, stay in MEASURE.
  - With edges at cycles t0 and t1, result = t1-t0.
  - Edges on consecutive cycles give 1.
- MEASURE, edge_in=0, cnt==TIMEOUT:
  - timeout=1 for exactly one cycle.
  - state<=IDLE, cnt<=0, no result produced.
- An edge in the same cycle as cnt==TIMEOUT wins: result=TIMEOUT, no timeout pulse.
- Counter never wraps; TIMEOUT bounds it.
- Output handshake:
  - Transfer occurs when period_valid && period_ready.
  - period_data and period_valid are registered and update the cycle after the edge (latency 1).
  - Once period_valid is high, period_data is stable until the transfer.
  - New result while period_valid && !period_ready: result dropped, overrun<=1; held data unchanged.
  - New result while period_valid && period_ready: new result loaded, period_valid stays 1, no overrun.
  - Transfer without a new result: period_valid<=0; period_data keeps its last value.
- clear:
  - Highest priority below rst_n.
  - state<=IDLE, cnt<=0, period_valid<=0, overrun<=0, timeout<=0.
  - An edge_in in the same cycle is ignored.
- period_ready is ignored when period_valid=0.

Optional Feature:
- Macro: EDGE_PERIOD_MINMAX_EN.
- Defined:
  - Adds outputs min_period [CNT_W-1:0] and max_period [CNT_W-1:0].
  - Reset and clear values: min=all-ones, max=0.
  - Updated on every completed measurement, including ones dropped by overrun.
  - Latency 1, same as period_data.
- Undefined: ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package edge_pkg holds:
  - state encoding (IDLE=1'b0, MEASURE=1'b1);
  - default CNT_W and TIMEOUT constants, reused by the other edge-domain blocks.
- One natural sub-module: period_out_reg, a one-entry valid/ready holding register with drop/overrun logic.
  - Parameterised by width.
  - Instantiated once here; reusable by other event producers.

Test Plan:
- Reset release, edges at cycles 10 and 17, ready=1 -> period_data=7, period_valid high for the one cycle after cycle 17; no timeout.
- Edges on 4 consecutive cycles, ready=1 -> three results of 1, back-to-back valid with no gaps.
- TIMEOUT=20, one edge then silence -> timeout pulses once exactly 20 cycles after the edge, state IDLE; next edge starts a fresh measurement and produces no result.
- ready=0, edges giving periods 5 then 8 -> period_data stays 5 and overrun=1. Raise ready -> transfer of 5, valid drops. clear -> overrun=0.
- Edge arriving on the same cycle as a transfer of a held result -> new value loaded, period_valid stays 1, overrun stays 0.
- rst_n asserted mid-MEASURE with valid=1 -> all outputs 0 immediately; first edge after release yields no result. With EDGE_PERIOD_MINMAX_EN, periods 9,3,12 -> min=3, max=12.
